// File: rtl/mips_pkg.sv
// Shared MIPS pipeline types: data-path widths and the MEM-stage FSM encoding.
// No logic, so no latency.
// No flow control of its own.
package mips_pkg;

  localparam int WORD_W     = 32;
  localparam int REG_ADDR_W = 5;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mem_state_e;

endpackage

// File: rtl/data_memory.sv
// Word-addressed data RAM: synchronous write, combinational read of the addressed word.
// Latency: the write lands at the clock edge; the read reflects the array contents.
// Backpressure: none; the caller decides when a write commits.
module data_memory
  import mips_pkg::*;
#(
  parameter int DEPTH = 256
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [WORD_W-1:0]        wdata,
  output logic [WORD_W-1:0]        rdata
);

  logic [WORD_W-1:0] mem [DEPTH];

  // Commit a store on the edge where the stage signals completion.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/memory_stage.sv
// MIPS MEM stage: load/store against data_memory, drives MEM/WB and the writeback forward.
// Latency: an access occupies LATENCY cycles; MemStall is high for the first LATENCY-1.
// Backpressure: MemStall freezes upstream; optional MEM_MISALIGN_TRAP_EN suppresses unaligned accesses.
module memory_stage
  import mips_pkg::*;
#(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WORD_W-1:0]     ExMemAluout,
  input  logic [WORD_W-1:0]     ExMemReadData2,
  input  logic [REG_ADDR_W-1:0] ExMemDestination_Rt_RdOutput,
  input  logic                  ExMemWriteRegEnable,
  input  logic                  ExMemWriteMemoryEnable,
  input  logic                  ExMemReadMemoryEnable,
  input  logic                  ExMemwritebackRegCtrl,
  output logic                  MemStall,
  output logic [WORD_W-1:0]     MemWbAluout,
  output logic [WORD_W-1:0]     MemWbReadData,
  output logic [REG_ADDR_W-1:0] MemWbDestination,
  output logic                  MemWbWriteRegEnable,
  output logic                  MemWbwritebackRegCtrl,
  output logic [WORD_W-1:0]     WriteBackValue
`ifdef MEM_MISALIGN_TRAP_EN
  ,
  output logic                  MisalignFault
`endif
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = (LATENCY > 2) ? $clog2(LATENCY) : 1;
  // The IDLE cycle that starts an access already counts as one stall cycle.
  localparam logic [CNT_W-1:0] CNT_LOAD = (LATENCY > 1) ? CNT_W'(LATENCY - 2) : '0;

  mem_state_e        state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic              access, misalign, pass, complete, mem_we;
  logic [WORD_W-1:0] mem_rdata, load_data;
  logic [AW-1:0]     word_idx;

  assign access   = ExMemReadMemoryEnable | ExMemWriteMemoryEnable;
  assign word_idx = ExMemAluout[AW+1:2];

`ifdef MEM_MISALIGN_TRAP_EN
  assign misalign = access & (|ExMemAluout[1:0]);
`else
  assign misalign = 1'b0;
`endif

  // Upper address bits wrap; byte offset only matters with the trap enabled.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{ExMemAluout[WORD_W-1:AW+2], ExMemAluout[1:0]};

  // State and latency counter; reset abandons any access in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next state, stall and completion decode.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    MemStall  = 1'b0;
    pass      = 1'b0;
    complete  = 1'b0;
    case (state)
      IDLE: begin
        if (!access) begin
          pass = 1'b1;
        end else if (LATENCY == 1 || misalign) begin
          complete = 1'b1;
        end else begin
          MemStall  = 1'b1;
          cnt_nxt   = CNT_LOAD;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (cnt != '0) begin
          MemStall = 1'b1;
          cnt_nxt  = cnt - 1'b1;
        end else begin
          complete  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // A store commits only on its completing edge, never under reset or a trapped access.
  assign mem_we    = complete & ExMemWriteMemoryEnable & ~misalign & ~rst;
  // Read-and-write together, or a trapped access, returns zero load data.
  assign load_data = (complete && ExMemReadMemoryEnable && !ExMemWriteMemoryEnable && !misalign)
                     ? mem_rdata : '0;

  data_memory #(.DEPTH(DEPTH)) u_data_memory (
    .clk   (clk),
    .we    (mem_we),
    .addr  (word_idx),
    .wdata (ExMemReadData2),
    .rdata (mem_rdata)
  );

  // MEM/WB register: capture on pass-through or completion, otherwise insert a bubble.
  always_ff @(posedge clk) begin
    if (rst || !(pass || complete)) begin
      MemWbAluout           <= '0;
      MemWbReadData         <= '0;
      MemWbDestination      <= '0;
      MemWbWriteRegEnable   <= 1'b0;
      MemWbwritebackRegCtrl <= 1'b0;
    end else begin
      MemWbAluout           <= ExMemAluout;
      MemWbReadData         <= load_data;
      MemWbDestination      <= ExMemDestination_Rt_RdOutput;
      MemWbWriteRegEnable   <= ExMemWriteRegEnable & ~misalign;
      MemWbwritebackRegCtrl <= ExMemwritebackRegCtrl;
    end
  end

  assign WriteBackValue = MemWbwritebackRegCtrl ? MemWbReadData : MemWbAluout;

`ifdef MEM_MISALIGN_TRAP_EN
  // Sticky fault: set by any unaligned access, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      MisalignFault <= 1'b0;
    end else if (misalign && state == IDLE) begin
      MisalignFault <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_memory_stage.sv
// Directed bench for memory_stage: three instances with LATENCY 1, 2 and 3 (index = LATENCY-1).
// Inputs driven 1 time unit after the rising edge, outputs sampled before the next edge.
// Honours MEM_MISALIGN_TRAP_EN when defined.
module tb_memory_stage;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] alu [3];
  logic [31:0] rd2 [3];
  logic [4:0]  dst [3];
  logic        wre [3];
  logic        wme [3];
  logic        rme [3];
  logic        wbc [3];

  wire         stall [3];
  wire  [31:0] mwalu [3];
  wire  [31:0] mwrd  [3];
  wire  [4:0]  mwdst [3];
  wire         mwwre [3];
  wire         mwwbc [3];
  wire  [31:0] wbv   [3];
`ifdef MEM_MISALIGN_TRAP_EN
  wire         fault [3];
`endif

  int checks = 0;
  int errors = 0;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    memory_stage #(.DEPTH(256), .LATENCY(g + 1)) dut (
      .clk                          (clk),
`ifdef MEM_MISALIGN_TRAP_EN
      .MisalignFault                (fault[g]),
`endif
      .rst                          (rst),
      .ExMemAluout                  (alu[g]),
      .ExMemReadData2               (rd2[g]),
      .ExMemDestination_Rt_RdOutput (dst[g]),
      .ExMemWriteRegEnable          (wre[g]),
      .ExMemWriteMemoryEnable       (wme[g]),
      .ExMemReadMemoryEnable        (rme[g]),
      .ExMemwritebackRegCtrl        (wbc[g]),
      .MemStall                     (stall[g]),
      .MemWbAluout                  (mwalu[g]),
      .MemWbReadData                (mwrd[g]),
      .MemWbDestination             (mwdst[g]),
      .MemWbWriteRegEnable          (mwwre[g]),
      .MemWbwritebackRegCtrl        (mwwbc[g]),
      .WriteBackValue               (wbv[g])
    );
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int i, input logic [31:0] a, input logic [31:0] d, input logic [4:0] r,
                       input logic we_reg, input logic wmem, input logic rmem, input logic wb);
    alu[i] = a; rd2[i] = d; dst[i] = r;
    wre[i] = we_reg; wme[i] = wmem; rme[i] = rmem; wbc[i] = wb;
  endtask

  task automatic idle(input int i);
    drive(i, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Holds the presented access until it completes; returns the number of stall cycles seen.
  task automatic run_access(input int i, output int nstall);
    nstall = 0;
    #1;
    while (stall[i] === 1'b1 && nstall < 20) begin
      nstall++;
      tick();
    end
    tick();
    idle(i);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) idle(i);
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      checks++; if (stall[i] !== 1'b0) begin errors++; $display("FAIL reset_stall[%0d] got %b want 0", i, stall[i]); end
      checks++; if (mwalu[i] !== 32'h0) begin errors++; $display("FAIL reset_aluout[%0d] got %h want 0", i, mwalu[i]); end
      checks++; if (mwrd[i] !== 32'h0) begin errors++; $display("FAIL reset_readdata[%0d] got %h want 0", i, mwrd[i]); end
      checks++; if (mwdst[i] !== 5'd0) begin errors++; $display("FAIL reset_dest[%0d] got %0d want 0", i, mwdst[i]); end
      checks++; if (mwwre[i] !== 1'b0 || mwwbc[i] !== 1'b0) begin errors++; $display("FAIL reset_ctrl[%0d] got %b%b want 00", i, mwwre[i], mwwbc[i]); end
      checks++; if (wbv[i] !== 32'h0) begin errors++; $display("FAIL reset_wbv[%0d] got %h want 0", i, wbv[i]); end
`ifdef MEM_MISALIGN_TRAP_EN
      checks++; if (fault[i] !== 1'b0) begin errors++; $display("FAIL reset_fault[%0d] got %b want 0", i, fault[i]); end
`endif
    end
  endtask

  task automatic test_store_load();
    int n;
    drive(0, 32'h10, 32'hDEADBEEF, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    run_access(0, n);
    checks++; if (n != 0) begin errors++; $display("FAIL l1_store_stall got %0d want 0", n); end
    drive(0, 32'h10, 32'h0, 5'd3, 1'b1, 1'b0, 1'b1, 1'b1);
    #1;
    checks++; if (stall[0] !== 1'b0) begin errors++; $display("FAIL l1_load_stall got %b want 0", stall[0]); end
    tick();
    idle(0);
    checks++; if (wbv[0] !== 32'hDEADBEEF) begin errors++; $display("FAIL l1_load_wbv got %h want deadbeef", wbv[0]); end
    checks++; if (mwdst[0] !== 5'd3 || mwwre[0] !== 1'b1) begin errors++; $display("FAIL l1_load_dest got %0d/%b want 3/1", mwdst[0], mwwre[0]); end
    // Read and write together: write lands, read data forced to zero.
    drive(0, 32'h14, 32'h00000077, 5'd4, 1'b1, 1'b1, 1'b1, 1'b1);
    tick();
    idle(0);
    checks++; if (mwrd[0] !== 32'h0) begin errors++; $display("FAIL rdwr_readdata got %h want 0", mwrd[0]); end
    drive(0, 32'h14, 32'h0, 5'd4, 1'b1, 1'b0, 1'b1, 1'b1);
    run_access(0, n);
    checks++; if (mwrd[0] !== 32'h00000077) begin errors++; $display("FAIL rdwr_written got %h want 00000077", mwrd[0]); end
  endtask

  task automatic test_latency3_load();
    int n;
    drive(2, 32'h20, 32'hA5A50020, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    run_access(2, n);
    checks++; if (n != 2) begin errors++; $display("FAIL l3_store_stalls got %0d want 2", n); end
    drive(2, 32'h20, 32'h0, 5'd9, 1'b1, 1'b0, 1'b1, 1'b1);
    #1;
    checks++; if (stall[2] !== 1'b1) begin errors++; $display("FAIL l3_stall_c0 got %b want 1", stall[2]); end
    tick();
    checks++; if (stall[2] !== 1'b1) begin errors++; $display("FAIL l3_stall_c1 got %b want 1", stall[2]); end
    checks++; if (mwwre[2] !== 1'b0 || mwrd[2] !== 32'h0 || mwdst[2] !== 5'd0) begin errors++; $display("FAIL l3_bubble_c1 got %b/%h/%0d want 0/0/0", mwwre[2], mwrd[2], mwdst[2]); end
    tick();
    checks++; if (stall[2] !== 1'b0) begin errors++; $display("FAIL l3_stall_c2 got %b want 0", stall[2]); end
    checks++; if (mwwre[2] !== 1'b0) begin errors++; $display("FAIL l3_bubble_c2 got %b want 0", mwwre[2]); end
    tick();
    idle(2);
    checks++; if (mwrd[2] !== 32'hA5A50020 || wbv[2] !== 32'hA5A50020) begin errors++; $display("FAIL l3_load_data got %h/%h want a5a50020", mwrd[2], wbv[2]); end
    checks++; if (mwwre[2] !== 1'b1 || mwdst[2] !== 5'd9) begin errors++; $display("FAIL l3_load_ctrl got %b/%0d want 1/9", mwwre[2], mwdst[2]); end
  endtask

  task automatic test_reset_mid_store();
    int n;
    drive(2, 32'h40, 32'h0BADF00D, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    run_access(2, n);
    drive(2, 32'h40, 32'h00001234, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    checks++; if (stall[2] !== 1'b1) begin errors++; $display("FAIL rstmid_stall2 got %b want 1", stall[2]); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    idle(2);
    #1;
    checks++; if (stall[2] !== 1'b0) begin errors++; $display("FAIL rstmid_stall_after got %b want 0", stall[2]); end
    drive(2, 32'h40, 32'h0, 5'd2, 1'b1, 1'b0, 1'b1, 1'b1);
    run_access(2, n);
    checks++; if (n != 2) begin errors++; $display("FAIL rstmid_load_stalls got %0d want 2", n); end
    checks++; if (mwrd[2] !== 32'h0BADF00D) begin errors++; $display("FAIL rstmid_dropped got %h want 0badf00d", mwrd[2]); end
  endtask

  task automatic test_alu_op();
    drive(2, 32'h55, 32'h0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
    #1;
    checks++; if (stall[2] !== 1'b0) begin errors++; $display("FAIL alu_stall got %b want 0", stall[2]); end
    tick();
    idle(2);
    checks++; if (mwalu[2] !== 32'h55 || mwdst[2] !== 5'd7) begin errors++; $display("FAIL alu_capture got %h/%0d want 55/7", mwalu[2], mwdst[2]); end
    checks++; if (wbv[2] !== 32'h55 || mwwre[2] !== 1'b1 || mwrd[2] !== 32'h0) begin errors++; $display("FAIL alu_wbv got %h/%b/%h want 55/1/0", wbv[2], mwwre[2], mwrd[2]); end
  endtask

  task automatic test_misalign();
    int n;
    logic [31:0] exp;
    drive(0, 32'h40, 32'h11112222, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    run_access(0, n);
    drive(0, 32'h42, 32'h99998888, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    run_access(0, n);
    checks++; if (n != 0) begin errors++; $display("FAIL mis_stall got %0d want 0", n); end
`ifdef MEM_MISALIGN_TRAP_EN
    checks++; if (fault[0] !== 1'b1) begin errors++; $display("FAIL mis_fault_set got %b want 1", fault[0]); end
    tick();
    checks++; if (fault[0] !== 1'b1) begin errors++; $display("FAIL mis_fault_sticky got %b want 1", fault[0]); end
    exp = 32'h11112222;
`else
    exp = 32'h99998888;
`endif
    drive(0, 32'h40, 32'h0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1);
    run_access(0, n);
    checks++; if (mwrd[0] !== exp) begin errors++; $display("FAIL mis_word40 got %h want %h", mwrd[0], exp); end
  endtask

  task automatic test_back_to_back();
    int n;
    drive(1, 32'h80, 32'hAAAA0080, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    run_access(1, n);
    checks++; if (n != 1) begin errors++; $display("FAIL l2_store_stalls got %0d want 1", n); end
    drive(1, 32'h84, 32'hBBBB0084, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    run_access(1, n);
    drive(1, 32'h80, 32'h0, 5'd10, 1'b1, 1'b0, 1'b1, 1'b1);
    #1;
    checks++; if (stall[1] !== 1'b1) begin errors++; $display("FAIL b2b_a_stall got %b want 1", stall[1]); end
    tick();
    checks++; if (stall[1] !== 1'b0 || mwwre[1] !== 1'b0) begin errors++; $display("FAIL b2b_a_bubble got %b/%b want 0/0", stall[1], mwwre[1]); end
    tick();
    drive(1, 32'h84, 32'h0, 5'd11, 1'b1, 1'b0, 1'b1, 1'b1);
    #1;
    checks++; if (mwrd[1] !== 32'hAAAA0080 || mwdst[1] !== 5'd10 || mwwre[1] !== 1'b1) begin errors++; $display("FAIL b2b_a_done got %h/%0d/%b want aaaa0080/10/1", mwrd[1], mwdst[1], mwwre[1]); end
    checks++; if (stall[1] !== 1'b1) begin errors++; $display("FAIL b2b_b_stall got %b want 1", stall[1]); end
    tick();
    checks++; if (stall[1] !== 1'b0 || mwwre[1] !== 1'b0) begin errors++; $display("FAIL b2b_b_bubble got %b/%b want 0/0", stall[1], mwwre[1]); end
    tick();
    idle(1);
    checks++; if (mwrd[1] !== 32'hBBBB0084 || mwdst[1] !== 5'd11 || mwwre[1] !== 1'b1) begin errors++; $display("FAIL b2b_b_done got %h/%0d/%b want bbbb0084/11/1", mwrd[1], mwdst[1], mwwre[1]); end
    tick();
    checks++; if (mwwre[1] !== 1'b0 || mwdst[1] !== 5'd0) begin errors++; $display("FAIL b2b_no_dup got %b/%0d want 0/0", mwwre[1], mwdst[1]); end
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_latency3_load();
    test_reset_mid_store();
    test_alu_op();
    test_misalign();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
